// File: rtl/apb_resp_pkg.sv
// Shared types and constants for the APB responder register file.
package apb_resp_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StAck  = 2'd2,
    StDone = 2'd3
  } state_e;

  localparam logic [1:0]  LANE_LO       = 2'b01;
  localparam logic [1:0]  LANE_HI       = 2'b10;
  localparam logic [31:0] ERR_RDATA     = 32'hDEAD_BEEF;
  localparam int unsigned WAIT_CNT_BITS = 4;

endpackage

// File: rtl/apb_resp_regbank.sv
// Word-addressed 32-bit register bank with per-halfword write enables and a registered read port.
module apb_resp_regbank
  import apb_resp_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [31:0]          wdata,
  input  logic                 re,
  input  logic                 rclr,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [31:0]          rdata
);

  localparam int unsigned Depth = 1 << ADDR_BITS;

  logic [31:0] mem_q [Depth];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if ((we & LANE_LO) != 2'b00) mem_q[waddr][15:0]  <= wdata[15:0];
      if ((we & LANE_HI) != 2'b00) mem_q[waddr][31:16] <= wdata[31:16];
    end
  end

  // rclr zeroes the read register so completions that return no data show 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end else if (rclr) begin
      rdata_q <= '0;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/apb_resp_regfile.sv
// Bridge-request responder executing beats against a local register bank.
// Optional error responses for out-of-range addresses: define APB_RESP_ERR_EN.
module apb_resp_regfile
  import apb_resp_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ID    = 7'd1,
  parameter int unsigned ADDR_BITS   = 4,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic        i_write,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_strobe,
  input  logic [6:0]  i_slave_sel,
  output logic        o_ready,
  output logic [31:0] o_rdata,
  output logic        o_err
);

  localparam logic [WAIT_CNT_BITS-1:0] CntLast =
    (WAIT_CYCLES == 0) ? '0 : WAIT_CNT_BITS'(WAIT_CYCLES - 1);

  state_e                   state_q, state_d;
  logic [WAIT_CNT_BITS-1:0] cnt_q, cnt_d;
  logic                     ready_q;
  logic                     wr_q;
  logic [31:0]              addr_q, wdata_q;
  logic [1:0]               strb_q;

  logic                     accept, enter_ack, in_range;
  logic                     req_write;
  logic [31:0]              req_addr, req_wdata;
  logic [1:0]               req_strb;
  logic [1:0]               bank_we;
  logic                     bank_re, bank_rclr;
  logic [31:0]              bank_rdata;

  assign accept = (state_q == StIdle) && i_valid && (i_slave_sel == SLAVE_ID);

  // With zero wait states the beat completes straight from IDLE, before the latch is loaded.
  always_comb begin
    req_write = wr_q;
    req_addr  = addr_q;
    req_wdata = wdata_q;
    req_strb  = strb_q;
    if (state_q == StIdle) begin
      req_write = i_write;
      req_addr  = i_addr;
      req_wdata = i_wdata;
      req_strb  = i_strobe;
    end
  end

  assign in_range = (req_addr >> ADDR_BITS) == 32'd0;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    enter_ack = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          cnt_d = '0;
          if (WAIT_CYCLES == 0) begin
            state_d   = StAck;
            enter_ack = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (cnt_q == CntLast) begin
          state_d   = StAck;
          enter_ack = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StAck:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= enter_ack;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else if (accept) begin
      wr_q    <= i_write;
      addr_q  <= i_addr;
      wdata_q <= i_wdata;
      strb_q  <= i_strobe;
    end
  end

  assign bank_we   = (enter_ack && req_write && in_range) ? req_strb : 2'b00;
  assign bank_re   = enter_ack && !req_write && in_range;
  assign bank_rclr = enter_ack && !bank_re;

  apb_resp_regbank #(
    .ADDR_BITS(ADDR_BITS)
  ) u_regbank (
    .clk  (clk),
    .rst  (rst),
    .we   (bank_we),
    .waddr(req_addr[ADDR_BITS-1:0]),
    .wdata(req_wdata),
    .re   (bank_re),
    .rclr (bank_rclr),
    .raddr(req_addr[ADDR_BITS-1:0]),
    .rdata(bank_rdata)
  );

  assign o_ready = ready_q;

`ifdef APB_RESP_ERR_EN
  logic err_q;
  logic oor_rd_q;

  // oor_rd_q is sticky so the error pattern holds like any other read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q    <= 1'b0;
      oor_rd_q <= 1'b0;
    end else begin
      err_q <= enter_ack && !in_range;
      if (enter_ack) oor_rd_q <= !req_write && !in_range;
    end
  end

  assign o_err   = err_q;
  assign o_rdata = oor_rd_q ? ERR_RDATA : bank_rdata;
`else
  assign o_err   = 1'b0;
  assign o_rdata = bank_rdata;
`endif

endmodule
